// File: rtl/booth_mult_arbiter_if.sv
// booth_mult_arbiter_if: requester and multiplier-side signals of the Booth multiplier arbiter
interface booth_mult_arbiter_if #(
  parameter int L_word = 4,
  parameter int N_REQ = 4,
  parameter int L_ID = 2
);
  logic [N_REQ-1:0] i_req;
  logic [N_REQ*L_word-1:0] i_word1;
  logic [N_REQ*L_word-1:0] i_word2;
  logic [N_REQ-1:0] o_gnt;
  logic o_valid;
  logic [L_ID-1:0] o_id;
  logic [2*L_word-1:0] o_product;
  logic o_err;
  logic o_busy;
  logic o_mul_start;
  logic [L_word-1:0] o_mul_word1;
  logic [L_word-1:0] o_mul_word2;
  logic i_mul_ready;
  logic [2*L_word-1:0] i_mul_product;
  logic i_mul_err;
  modport slave (
    input i_req, i_word1, i_word2, i_mul_ready, i_mul_product, i_mul_err,
    output o_gnt, o_valid, o_id, o_product, o_err, o_busy, o_mul_start, o_mul_word1, o_mul_word2
  );
  modport master (
    output i_req, i_word1, i_word2, i_mul_ready, i_mul_product, i_mul_err,
    input o_gnt, o_valid, o_id, o_product, o_err, o_busy, o_mul_start, o_mul_word1, o_mul_word2
  );
endinterface

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin sharing of one sequential Booth multiplier, with timeout
module booth_mult_arbiter #(
  parameter int L_word = 4,
  parameter int N_REQ = 4,
  parameter int L_ID = 2,
  parameter int T_MAX = 32
) (
  input logic i_clk,
  input logic i_rst_n,
  booth_mult_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state;
  logic [L_ID-1:0] ptr, id, win;
  logic [7:0] cnt;
  logic tmo;
  // Descending scan so the lane closest after ptr wins.
  always_comb begin
    win = ptr;
    for (int i = N_REQ; i >= 1; i--)
      if (bus.i_req[(int'(ptr) + i) % N_REQ]) win = L_ID'((int'(ptr) + i) % N_REQ);
  end
  assign tmo = cnt == 8'(T_MAX - 1);
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      ptr <= L_ID'(N_REQ - 1);
      id <= '0;
      cnt <= '0;
      bus.o_gnt <= '0;
      bus.o_valid <= 1'b0;
      bus.o_id <= '0;
      bus.o_product <= '0;
      bus.o_err <= 1'b0;
      bus.o_busy <= 1'b0;
      bus.o_mul_start <= 1'b0;
      bus.o_mul_word1 <= '0;
      bus.o_mul_word2 <= '0;
    end else begin
      bus.o_gnt <= '0;
      bus.o_valid <= 1'b0;
      bus.o_mul_start <= 1'b0;
      case (state)
        IDLE: if (|bus.i_req) begin
          bus.o_gnt <= N_REQ'(1) << win;
          bus.o_mul_word1 <= bus.i_word1[int'(win)*L_word +: L_word];
          bus.o_mul_word2 <= bus.i_word2[int'(win)*L_word +: L_word];
          ptr <= win;
          id <= win;
          bus.o_busy <= 1'b1;
          state <= START;
        end
        START: begin
          bus.o_mul_start <= 1'b1;
          cnt <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          cnt <= cnt + 8'd1;
          if (tmo) begin
            bus.o_valid <= 1'b1;
            bus.o_err <= 1'b1;
            bus.o_product <= '0;
            bus.o_id <= id;
            bus.o_busy <= 1'b0;
            state <= IDLE;
          end else if (!bus.i_mul_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          cnt <= cnt + 8'd1;
          if (bus.i_mul_ready || tmo) begin
            bus.o_valid <= 1'b1;
            bus.o_err <= bus.i_mul_ready ? bus.i_mul_err : 1'b1;
            bus.o_product <= bus.i_mul_ready ? bus.i_mul_product : '0;
            bus.o_id <= id;
            bus.o_busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: directed checks of arbitration, products, timeout and reset abort
module tb_booth_mult_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  booth_mult_arbiter_if #(.L_word(4), .N_REQ(4), .L_ID(2)) bus ();
  booth_mult_arbiter #(.L_word(4), .N_REQ(4), .L_ID(2), .T_MAX(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  logic mrdy = 1'b1;
  logic merr = 1'b0;
  logic [7:0] mprod = '0;
  logic [7:0] mp = '0;
  int mcnt = 0;
  int lat = 3;
  logic stuck = 1'b0;
  logic err_mode = 1'b0;
  logic signed [7:0] sa, sb;
  assign sa = $signed(bus.o_mul_word1);
  assign sb = $signed(bus.o_mul_word2);
  assign bus.i_mul_ready = mrdy;
  assign bus.i_mul_product = mprod;
  assign bus.i_mul_err = merr;
  // Behavioural multiplier: Ready drops after start, product appears lat cycles later.
  always @(posedge clk) begin
    if (bus.o_mul_start && !stuck) begin
      mrdy <= 1'b0;
      mcnt <= lat;
      mp <= sa * sb;
    end else if (!mrdy && mcnt == 0) begin
      mrdy <= 1'b1;
      mprod <= mp;
      merr <= err_mode;
    end else if (!mrdy) mcnt <= mcnt - 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_lane(input int k, input logic [3:0] a, input logic [3:0] b);
    bus.i_word1[k*4 +: 4] = a;
    bus.i_word2[k*4 +: 4] = b;
  endtask
  task automatic wait_gnt(output int lane);
    int n = 0;
    lane = -1;
    do begin @(negedge clk); n++; end while (bus.o_gnt == 0 && n < 100);
    if (bus.o_gnt == 0) begin
      checks++; failures++;
      $error("FAIL gnt_wait observed=none expected=grant");
    end else for (int i = 0; i < 4; i++) if (bus.o_gnt[i]) lane = i;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.o_valid && n < 200);
    if (!bus.o_valid) begin
      checks++; failures++;
      $error("FAIL valid_wait observed=none expected=valid");
    end
  endtask
  task automatic job(input string tag, input logic [3:0] req, input int exp_lane,
                     input logic [7:0] exp_prod, input logic exp_err);
    int lane, n;
    bus.i_req = req;
    wait_gnt(lane);
    bus.i_req = '0;
    chk({tag, "_gnt"}, lane, exp_lane);
    wait_valid(n);
    chk({tag, "_id"}, bus.o_id, exp_lane);
    chk({tag, "_prod"}, bus.o_product, exp_prod);
    chk({tag, "_err"}, bus.o_err, exp_err);
  endtask
  initial begin
    int lane, n, vcnt;
    int order[5] = '{0, 1, 2, 3, 0};
    bus.i_req = '0;
    bus.i_word1 = '0;
    bus.i_word2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {bus.o_gnt, bus.o_valid, bus.o_id, bus.o_product, bus.o_err, bus.o_busy,
                       bus.o_mul_start, bus.o_mul_word1, bus.o_mul_word2}, 0);
    rst_n = 1'b1;
    // Single job, lane 2: 3 x 5, with grant/start/busy timing
    set_lane(2, 4'h3, 4'h5);
    bus.i_req = 4'b0100;
    wait_gnt(lane);
    bus.i_req = '0;
    chk("single_gnt_vec", bus.o_gnt, 4'b0100);
    chk("single_busy", bus.o_busy, 1);
    chk("single_start_early", bus.o_mul_start, 0);
    @(negedge clk);
    chk("single_start", bus.o_mul_start, 1);
    chk("single_gnt_drop", bus.o_gnt, 0);
    @(negedge clk);
    chk("single_start_once", bus.o_mul_start, 0);
    wait_valid(n);
    chk("single_id", bus.o_id, 2);
    chk("single_prod", bus.o_product, 8'h0F);
    chk("single_err", bus.o_err, 0);
    chk("single_busy_off", bus.o_busy, 0);
    @(negedge clk);
    chk("single_valid_pulse", bus.o_valid, 0);
    chk("single_prod_hold", bus.o_product, 8'h0F);
    // Signed operands
    set_lane(0, 4'hD, 4'h5);
    job("neg3x5", 4'b0001, 0, 8'hF1, 1'b0);
    set_lane(1, 4'h8, 4'h8);
    job("neg8xneg8", 4'b0010, 1, 8'h40, 1'b0);
    // ptr=1, lanes 0 and 3: lane 3 first, then lane 0
    set_lane(3, 4'h2, 4'h3);
    set_lane(0, 4'h1, 4'h4);
    bus.i_req = 4'b1001;
    wait_gnt(lane);
    chk("rr03_first", lane, 3);
    wait_valid(n);
    chk("rr03_first_prod", bus.o_product, 8'h06);
    wait_gnt(lane);
    bus.i_req = '0;
    chk("rr03_second", lane, 0);
    wait_valid(n);
    chk("rr03_second_id", bus.o_id, 0);
    // Reset while in WAIT_DONE aborts the job
    lat = 10;
    set_lane(2, 4'h2, 4'h2);
    bus.i_req = 4'b0100;
    wait_gnt(lane);
    bus.i_req = '0;
    repeat (4) @(negedge clk);
    chk("abort_pending", {bus.o_busy, bus.i_mul_ready}, 2'b10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_outs", {bus.o_gnt, bus.o_valid, bus.o_id, bus.o_product, bus.o_err, bus.o_busy,
                       bus.o_mul_start, bus.o_mul_word1, bus.o_mul_word2}, 0);
    vcnt = 0;
    repeat (20) begin @(negedge clk); if (bus.o_valid) vcnt++; end
    chk("abort_no_valid", vcnt, 0);
    lat = 3;
    // Round-robin with all lanes held high
    for (int k = 0; k < 4; k++) set_lane(k, 4'(k + 1), 4'h2);
    bus.i_req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_gnt(lane);
      if (j == 4) bus.i_req = '0;
      chk($sformatf("rr_gnt%0d", j), lane, order[j]);
      wait_valid(n);
      chk($sformatf("rr_id%0d", j), bus.o_id, order[j]);
      chk($sformatf("rr_prod%0d", j), bus.o_product, 2 * (order[j] + 1));
    end
    // Operand change after grant has no effect
    set_lane(1, 4'h6, 4'h3);
    bus.i_req = 4'b0010;
    wait_gnt(lane);
    bus.i_req = '0;
    @(negedge clk);
    bus.i_word1[4 +: 4] = 4'h1;
    @(negedge clk);
    chk("stable_word1", bus.o_mul_word1, 4'h6);
    wait_valid(n);
    chk("stable_prod", bus.o_product, 8'h12);
    // Multiplier error flag is passed through
    err_mode = 1'b1;
    set_lane(3, 4'h7, 4'hF);
    job("mul_err", 4'b1000, 3, 8'hF9, 1'b1);
    err_mode = 1'b0;
    // Stuck multiplier: timeout T_MAX cycles after the start pulse
    stuck = 1'b1;
    set_lane(0, 4'h2, 4'h2);
    bus.i_req = 4'b0001;
    wait_gnt(lane);
    bus.i_req = '0;
    @(negedge clk);
    chk("tmo_start", bus.o_mul_start, 1);
    wait_valid(n);
    chk("tmo_cycles", n, 32);
    chk("tmo_err", bus.o_err, 1);
    chk("tmo_prod", bus.o_product, 0);
    chk("tmo_id", bus.o_id, 0);
    stuck = 1'b0;
    set_lane(2, 4'h5, 4'hE);
    job("after_tmo", 4'b0100, 2, 8'hF6, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Round-robin scheduler that shares one radix-2 Booth sequential multiplier among `N_REQ` requesters. Latches the winning requester's operands, issues the multiplier start pulse, and tracks the multiplier's `Ready` handshake. Returns the product, tagged with the requester index, as a one-cycle result strobe. Sits between the requesting engines and the multiplier core, and owns its `start` input exclusively.

## Interface
- `L_word`, 4: operand width; product is `2*L_word`.
- `N_REQ`, 4: number of requesters, 2..8.
- `L_ID`, 2: index width, `$clog2(N_REQ)`.
- `T_MAX`, 32: cycle budget from start pulse to multiplier done; must be ≥ 2 and fit in the 8-bit timeout counter.

Ports:
- `i_clk`  in  1  clock; single clock domain.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_req`  in  N_REQ  per-requester request level.
- `i_word1`  in  N_REQ*L_word  packed multiplicands; lane k = `[k*L_word +: L_word]`.
- `i_word2`  in  N_REQ*L_word  packed multipliers, same packing.
- `o_gnt`  out  N_REQ  one-hot, one-cycle grant; operands of that lane are captured.
- `o_valid`  out  1  one-cycle result strobe.
- `o_id`  out  L_ID  requester index of the current result.
- `o_product`  out  2*L_word  signed product.
- `o_err`  out  1  result error (multiplier error or timeout); qualified by `o_valid`.
- `o_busy`  out  1  high while a job is outstanding (state ≠ IDLE).
- `o_mul_start`  out  1  start pulse to the multiplier.
- `o_mul_word1`, `o_mul_word2`  out  L_word  latched operands; stable from grant until completion.
- `i_mul_ready`  in  1  multiplier `Ready`; low while computing.
- `i_mul_product`  in  2*L_word  multiplier product.
- `i_mul_err`  in  1  multiplier error flag.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE. Reset state is IDLE.
- IDLE:
  - If any `i_req` bit is set, pick the winner round-robin: the search starts at `ptr+1` mod `N_REQ`, where `ptr` is the last granted index.
  - At the edge: register `o_gnt`, latch the winner's `i_word1`/`i_word2` into `o_mul_word1`/`o_mul_word2`, set `ptr` and `id` to the winner, go to START.
- START: `o_mul_start`=1 for exactly this one cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY: wait for `i_mul_ready`=0, then go to WAIT_DONE.
- WAIT_DONE: wait for `i_mul_ready`=1. At that edge, register:
  - `o_product`←`i_mul_product`, `o_err`←`i_mul_err`, `o_id`←`id`, `o_valid`←1;
  - then go to IDLE.
- Timeout:
  - The counter increments in WAIT_BUSY and WAIT_DONE.
  - On reaching `T_MAX`, complete with `o_valid`=1, `o_err`=1, `o_product`=0, `o_id`=`id`, and go to IDLE.
  - A stuck multiplier thus never hangs the requesters.
- Requesters:
  - A requester may drop `i_req` after seeing its `o_gnt`.
  - A request still high after its result is re-arbitrated normally.
  - Requests are not queued; only the level in IDLE counts.
- Requests arriving outside IDLE are ignored until IDLE. Operand changes after grant have no effect on the current job.
- `o_product`, `o_id`, `o_err` hold their last value between strobes.

## Timing
- Reset (`i_rst_n`=0 at an edge):
  - all outputs 0 (`o_gnt`, `o_valid`, `o_id`, `o_product`, `o_err`, `o_busy`, `o_mul_start`, `o_mul_word1`/`o_mul_word2`);
  - state IDLE; `ptr`=`N_REQ`-1, so lane 0 has first priority.
- Reset mid-operation aborts the job: no `o_valid` for it, and the multiplier result is discarded.
- Per-job cycle count, with `i_req` sampled at edge E0:
  - `o_gnt` is high in cycle E0+1 and `o_mul_start` in E0+2.
  - `o_valid` rises one cycle after the edge at which `i_mul_ready` is sampled high in WAIT_DONE.
- Back-to-back jobs: IDLE in the `o_valid` cycle may grant again. Minimum spacing between grants is 4 cycles plus the multiplier latency.
- Simultaneous requests: exactly one grant per job. No lane waits more than `N_REQ`-1 other jobs.
- `o_busy` is high from the `o_gnt` cycle to the cycle before `o_valid`, inclusive.

## Test plan
- Single job: lane 2 requests 3 × 5 (L_word=4) → `o_gnt`=4'b0100 one cycle, one `o_mul_start` pulse, then `o_valid` with `o_id`=2, `o_product`=8'h0F, `o_err`=0.
- Signed operands: lane 0 requests −3 × 5 (4'hD, 4'h5) → `o_product`=8'hF1; lane 1 requests −8 × −8 → `o_product`=8'h40.
- Round-robin: all four lanes hold `i_req` high continuously → grant order 0,1,2,3,0 and one `o_valid` per grant with matching `o_id`. Then with `ptr`=1 and only lanes 0 and 3 requesting → 3 is granted before 0.
- Timeout: the bench model holds `i_mul_ready`=1 forever after start → `o_valid` with `o_err`=1 and `o_product`=0 after `T_MAX` cycles; the next request is then served normally.
- Reset mid-job: assert `i_rst_n`=0 in WAIT_DONE → next cycle all outputs are 0 and state is IDLE; no `o_valid` for the aborted job; the next grant goes to lane 0.
- Operand stability: change lane 1's `i_word1` the cycle after its `o_gnt` → `o_mul_word1` is unchanged and the product uses the latched value.
